// File: rtl/bcd_countdown_timer.sv
// Multi-digit packed-BCD countdown timer with a valid/ready preset port,
// start/pause/clear strobes and an optional auto-reload on expiry.
module bcd_countdown_timer #(
   parameter int DIGITS      = 4,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [4*DIGITS-1:0] load_value,
   input  logic                start,
   input  logic                pause,
   input  logic                tick,
   output logic [4*DIGITS-1:0] count,
   output logic                running,
   output logic                expired,
   output logic                load_error
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ZERO = '0;
   localparam logic [W-1:0] ONE  = W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      RUN    = 2'd2,
      PAUSED = 2'd3
   } state_t;

   state_t         state, state_next;
   logic [W-1:0]   count_next;
   logic [W-1:0]   reload, reload_next;
   logic           expired_next;
   logic           load_error_next;
   logic           load_fire;

   function automatic logic bcd_ok(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Ripple borrow: a zero digit becomes 9 and passes the borrow upward.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      logic [3:0]   d;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               d = 4'd9;
            end else begin
               d      = d - 4'd1;
               borrow = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   assign running    = (state == RUN);
   assign load_ready = (state != RUN);
   assign load_fire  = load_valid & load_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         count      <= '0;
         reload     <= '0;
         expired    <= 1'b0;
         load_error <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         reload     <= reload_next;
         expired    <= expired_next;
         load_error <= load_error_next;
      end
   end

   always_comb begin
      state_next      = state;
      count_next      = count;
      reload_next     = reload;
      expired_next    = 1'b0;
      load_error_next = 1'b0;
      unique case (1'b1)
         clear: begin
            state_next  = IDLE;
            count_next  = '0;
            reload_next = '0;
         end
         load_fire: begin
            if (bcd_ok(load_value)) begin
               count_next  = load_value;
               reload_next = load_value;
               state_next  = ARMED;
            end else begin
               load_error_next = 1'b1;
            end
         end
         default: begin
            if (state == RUN && pause) begin
               state_next = PAUSED;
            end else if ((state == ARMED || state == PAUSED) && start) begin
               state_next = RUN;
            end
            if (state == RUN && tick) begin
               if (count == ZERO) begin
                  // Started at zero: never wraps or free-runs.
                  expired_next = 1'b1;
                  state_next   = IDLE;
               end else if (count == ONE) begin
                  expired_next = 1'b1;
                  if (AUTO_RELOAD) begin
                     count_next = reload;
                  end else begin
                     count_next = '0;
                     state_next = IDLE;
                  end
               end else begin
                  count_next = bcd_dec(count);
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer; two instances (reload off/on)
// share stimulus and a scoreboard queue holds expected output vectors.
module tb_bcd_countdown_timer;

   logic        clk;
   logic        reset_n;
   logic        clear;
   logic        load_valid;
   logic [15:0] load_value;
   logic        start;
   logic        pause;
   logic        tick;

   logic        load_ready0, running0, expired0, load_error0;
   logic [15:0] count0;
   logic        load_ready1, running1, expired1, load_error1;
   logic [15:0] count1;

   int checks;
   int errors;

   logic [19:0] exp_q[$];

   bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .load_valid(load_valid), .load_ready(load_ready0),
      .load_value(load_value), .start(start), .pause(pause),
      .tick(tick), .count(count0), .running(running0),
      .expired(expired0), .load_error(load_error0)
   );

   bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .load_valid(load_valid), .load_ready(load_ready1),
      .load_value(load_value), .start(start), .pause(pause),
      .tick(tick), .count(count1), .running(running1),
      .expired(expired1), .load_error(load_error1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {count, running, expired, load_error, load_ready}
   function automatic logic [19:0] ev(
      input logic [15:0] c, input logic r,
      input logic e, input logic le, input logic rdy);
      return {c, r, e, le, rdy};
   endfunction

   task automatic chk(input string tag, input bit sel);
      logic [19:0] obs;
      logic [19:0] exp;
      obs = sel ? {count1, running1, expired1, load_error1, load_ready1}
                : {count0, running0, expired0, load_error0, load_ready0};
      exp = exp_q.pop_front();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(
      input string tag, input bit sel,
      input logic lv, input logic [15:0] v,
      input logic st, input logic pa, input logic ti,
      input logic cl, input logic [19:0] e);
      @(negedge clk);
      load_valid = lv;
      load_value = v;
      start      = st;
      pause      = pa;
      tick       = ti;
      clear      = cl;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      chk(tag, sel);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset_n    = 1'b0;
      clear      = 1'b0;
      load_valid = 1'b0;
      load_value = '0;
      start      = 1'b0;
      pause      = 1'b0;
      tick       = 1'b0;
      #12;
      exp_q.push_back(ev(16'h0, 0, 0, 0, 1));
      chk("reset0", 0);
      exp_q.push_back(ev(16'h0, 0, 0, 0, 1));
      chk("reset1", 1);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: simple expiry
      step("t1_load",  0, 1, 16'h0003, 0, 0, 0, 0, ev(16'h3, 0, 0, 0, 1));
      step("t1_start", 0, 0, 16'h0,    1, 0, 0, 0, ev(16'h3, 1, 0, 0, 0));
      step("t1_tick1", 0, 0, 16'h0,    0, 0, 1, 0, ev(16'h2, 1, 0, 0, 0));
      step("t1_tick2", 0, 0, 16'h0,    0, 0, 1, 0, ev(16'h1, 1, 0, 0, 0));
      step("t1_tick3", 0, 0, 16'h0,    0, 0, 1, 0, ev(16'h0, 0, 1, 0, 1));
      step("t1_after", 0, 0, 16'h0,    0, 0, 0, 0, ev(16'h0, 0, 0, 0, 1));

      // 2: borrow chain
      step("t2_load",  0, 1, 16'h1000, 0, 0, 0, 0, ev(16'h1000, 0, 0, 0, 1));
      step("t2_start", 0, 0, 16'h0,    1, 0, 0, 0, ev(16'h1000, 1, 0, 0, 0));
      step("t2_tick1", 0, 0, 16'h0,    0, 0, 1, 0, ev(16'h0999, 1, 0, 0, 0));
      step("t2_tick2", 0, 0, 16'h0,    0, 0, 1, 0, ev(16'h0998, 1, 0, 0, 0));
      step("t2_clear", 0, 0, 16'h0,    0, 0, 0, 1, ev(16'h0, 0, 0, 0, 1));

      // 3: bad preset rejected, good preset accepted
      step("t3_bad",   0, 1, 16'h00A5, 0, 0, 0, 0, ev(16'h0, 0, 0, 1, 1));
      step("t3_idle",  0, 0, 16'h0,    0, 0, 0, 0, ev(16'h0, 0, 0, 0, 1));
      step("t3_good",  0, 1, 16'h0005, 0, 0, 0, 0, ev(16'h5, 0, 0, 0, 1));
      step("t3_start", 0, 0, 16'h0,    1, 0, 0, 0, ev(16'h5, 1, 0, 0, 0));
      step("t3_clear", 0, 0, 16'h0,    0, 0, 0, 1, ev(16'h0, 0, 0, 0, 1));

      // 4: pause with simultaneous tick
      step("t4_load",  0, 1, 16'h0042, 0, 0, 0, 0, ev(16'h42, 0, 0, 0, 1));
      step("t4_start", 0, 0, 16'h0,    1, 0, 0, 0, ev(16'h42, 1, 0, 0, 0));
      step("t4_pause", 0, 0, 16'h0,    0, 1, 1, 0, ev(16'h41, 0, 0, 0, 1));
      for (int i = 0; i < 5; i++) begin
         step("t4_hold", 0, 0, 16'h0,  0, 0, 1, 0, ev(16'h41, 0, 0, 0, 1));
      end
      step("t4_resume", 0, 0, 16'h0,   1, 0, 0, 0, ev(16'h41, 1, 0, 0, 0));
      step("t4_tick",  0, 0, 16'h0,    0, 0, 1, 0, ev(16'h40, 1, 0, 0, 0));
      step("t4_clear", 0, 0, 16'h0,    0, 0, 0, 1, ev(16'h0, 0, 0, 0, 1));

      // 5: auto reload instance
      step("t5_load",  1, 1, 16'h0002, 0, 0, 0, 0, ev(16'h2, 0, 0, 0, 1));
      step("t5_start", 1, 0, 16'h0,    1, 0, 0, 0, ev(16'h2, 1, 0, 0, 0));
      step("t5_tick1", 1, 0, 16'h0,    0, 0, 1, 0, ev(16'h1, 1, 0, 0, 0));
      step("t5_tick2", 1, 0, 16'h0,    0, 0, 1, 0, ev(16'h2, 1, 1, 0, 0));
      step("t5_tick3", 1, 0, 16'h0,    0, 0, 1, 0, ev(16'h1, 1, 0, 0, 0));
      step("t5_tick4", 1, 0, 16'h0,    0, 0, 1, 0, ev(16'h2, 1, 1, 0, 0));
      step("t5_idle",  1, 0, 16'h0,    0, 0, 0, 0, ev(16'h2, 1, 0, 0, 0));
      step("t5_clear", 1, 0, 16'h0,    0, 0, 0, 1, ev(16'h0, 0, 0, 0, 1));

      // zero preset never free-runs, even with reload
      step("z_load",   1, 1, 16'h0000, 0, 0, 0, 0, ev(16'h0, 0, 0, 0, 1));
      step("z_start",  1, 0, 16'h0,    1, 0, 0, 0, ev(16'h0, 1, 0, 0, 0));
      step("z_tick",   1, 0, 16'h0,    0, 0, 1, 0, ev(16'h0, 0, 1, 0, 1));
      step("z_tick2",  1, 0, 16'h0,    0, 0, 1, 0, ev(16'h0, 0, 0, 0, 1));

      // 6: load during RUN, clear mid-run, async reset mid-run
      step("t6_load",  0, 1, 16'h0007, 0, 0, 0, 0, ev(16'h7, 0, 0, 0, 1));
      step("t6_start", 0, 0, 16'h0,    1, 0, 0, 0, ev(16'h7, 1, 0, 0, 0));
      step("t6_lvrun", 0, 1, 16'h0003, 0, 0, 0, 0, ev(16'h7, 1, 0, 0, 0));
      step("t6_lvtk",  0, 1, 16'h0003, 0, 0, 1, 0, ev(16'h6, 1, 0, 0, 0));
      step("t6_clear", 0, 0, 16'h0,    0, 0, 1, 1, ev(16'h0, 0, 0, 0, 1));
      step("t6_reld",  0, 1, 16'h0005, 0, 0, 0, 0, ev(16'h5, 0, 0, 0, 1));
      step("t6_rst",   0, 0, 16'h0,    1, 0, 0, 0, ev(16'h5, 1, 0, 0, 0));
      step("t6_tk",    0, 0, 16'h0,    0, 0, 1, 0, ev(16'h4, 1, 0, 0, 0));
      @(negedge clk);
      tick    = 1'b1;
      reset_n = 1'b0;
      #1;
      exp_q.push_back(ev(16'h0, 0, 0, 0, 1));
      chk("t6_async", 0);
      @(posedge clk);
      #1;
      exp_q.push_back(ev(16'h0, 0, 0, 0, 1));
      chk("t6_async_hold", 0);
      @(negedge clk);
      tick    = 1'b0;
      reset_n = 1'b1;
      step("t6_post",  0, 0, 16'h0,    0, 0, 1, 0, ev(16'h0, 0, 0, 0, 1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
